multdiv_sequencer: RTL and testbench

Multi-cycle sequencer for the processor's shared multiply/divide unit. Sits in the execute stage beside the instruction decoder. It detects `mul`/`div` ALU instructions, pulses the start strobe of the iterative multdiv unit, and stalls the front of the pipeline until the unit reports ready. It then issues exactly one register-file write-back: the product or quotient to `rd`, or the exception code to `$rstatus`.

---
 rtl/multdiv_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Execute-stage sequencer for the shared iterative multiply/divide unit.
//   It detects mul/div ALU instructions in X and pulses the unit's start
//   strobe. It holds the front of the pipeline until the unit reports ready,
//   then issues one register-file write-back. That write-back is the
//   product/quotient to rd, or the exception code to the status register.
//
// Parameters
//   RSTATUS_REG    register written on a multdiv exception
//   MUL_EXC_CODE   code written on multiply overflow
//   DIV_EXC_CODE   code written on divide exception
//   TIMEOUT_CYCLES WAIT watchdog limit (only with MULTDIV_TIMEOUT_EN)
//
// Optional feature macro: MULTDIV_TIMEOUT_EN
//   When defined, a watchdog ends WAIT after TIMEOUT_CYCLES with a forced
//   exception. When undefined, WAIT holds until md_rdy.
//
// Ports
//   clock, reset_n                  clock, async active-low reset
//   issue_valid/opcode/aluop/rd     X-stage instruction fields
//   md_ctrl_mult, md_ctrl_div       one-cycle start pulses (registered)
//   md_rdy, md_exception, md_result multdiv unit completion interface
//   stall                           combinational pipeline freeze
//   busy                            registered, state != IDLE
//   wb_valid, wb_reg, wb_data       registered one-cycle write-back
module multdiv_sequencer #(
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
`ifdef MULTDIV_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 40
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_opcode,
  input  logic [4:0]  issue_aluop,
  input  logic [4:0]  issue_rd,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic        md_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        md_op;
  logic        div_op;
  logic        is_div;
  logic [4:0]  rd_q;
  logic        complete;
  logic        exc_eff;

  assign div_op = (issue_aluop == 5'b00111);
  assign md_op  = issue_valid && (issue_opcode == 5'b00000) &&
                  ((issue_aluop == 5'b00110) || div_op);

`ifdef MULTDIV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // The counter sits at zero outside WAIT. It therefore reads zero on the
  // first WAIT cycle and saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A ready in the limit cycle takes priority over the watchdog.
  assign timeout  = (state == S_WAIT) && !md_rdy &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign complete = (state == S_WAIT) && (md_rdy || timeout);
  assign exc_eff  = md_rdy ? md_exception : 1'b1;
`else
  assign complete = (state == S_WAIT) && md_rdy;
  assign exc_eff  = md_exception;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (md_op) begin
          stall     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        stall     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (complete) begin
          state_nxt = S_DONE;
        end
      end
      // The held instruction leaves X as DONE ends, so no re-trigger here.
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the transition into the state
  // in which they are visible. This keeps every output except stall a
  // flop output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      busy         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      is_div       <= 1'b0;
      rd_q         <= '0;
    end else begin
      md_ctrl_mult <= (state == S_IDLE) && md_op && !div_op;
      md_ctrl_div  <= (state == S_IDLE) && md_op && div_op;
      busy         <= (state_nxt != S_IDLE);
      wb_valid     <= 1'b0;
      if ((state == S_IDLE) && md_op) begin
        is_div <= div_op;
        rd_q   <= issue_rd;
      end
      if (complete) begin
        if (exc_eff) begin
          wb_valid <= 1'b1;
          wb_reg   <= 5'(RSTATUS_REG);
          wb_data  <= is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
        end else begin
          wb_valid <= (rd_q != 5'd0);
          wb_reg   <= rd_q;
          wb_data  <= md_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_opcode;
  logic [4:0]  issue_aluop;
  logic [4:0]  issue_rd;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        md_rdy;
  logic        md_exception;
  logic [31:0] md_result;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  multdiv_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_opcode (issue_opcode),
    .issue_aluop  (issue_aluop),
    .issue_rd     (issue_rd),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_rdy       (md_rdy),
    .md_exception (md_exception),
    .md_result    (md_result),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge of the same cycle.
  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic issue(input logic v, input logic [4:0] opc, input logic [4:0] alu,
                       input logic [4:0] rd);
    issue_valid  = v;
    issue_opcode = opc;
    issue_aluop  = alu;
    issue_rd     = rd;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    md_rdy = 1'b0; md_exception = 1'b0; md_result = '0;
    #2;
    n_checks++; if ({md_ctrl_mult, md_ctrl_div, busy, wb_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got=%b exp=0000", {md_ctrl_mult, md_ctrl_div, busy, wb_valid}); end
    n_checks++; if (wb_reg !== 5'd0 || wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb got reg=%0d data=%h exp 0/0", wb_reg, wb_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    issue(1'b1, 5'd0, 5'b00110, 5'd3);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_mdop got=%b exp=1", stall); end
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    sample();
    sample();
    reset_n = 1'b1;
    sample();
    n_checks++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_release got busy=%b stall=%b exp 0/0", busy, stall); end
  endtask

  task automatic test_mul();
    logic e;
    next_edge();
    issue(1'b1, 5'd0, 5'b00110, 5'd3);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) next_edge();
      md_rdy    = (c == 10);
      md_result = (c == 10) ? 32'h0000_0064 : 32'hFFFF_FFFF;
      if (c == 12) issue(1'b0, 5'd0, 5'd0, 5'd0);
      sample();
      e = (c <= 10);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL mul_stall c=%0d got=%b exp=%b", c, stall, e); end
      e = (c == 1);
      n_checks++; if (md_ctrl_mult !== e || md_ctrl_div !== 1'b0) begin n_fail++; $display("FAIL mul_pulse c=%0d got mult=%b div=%b exp mult=%b div=0", c, md_ctrl_mult, md_ctrl_div, e); end
      e = (c >= 1 && c <= 11);
      n_checks++; if (busy !== e) begin n_fail++; $display("FAIL mul_busy c=%0d got=%b exp=%b", c, busy, e); end
      e = (c == 11);
      n_checks++; if (wb_valid !== e) begin n_fail++; $display("FAIL mul_wbvalid c=%0d got=%b exp=%b", c, wb_valid, e); end
      if (c == 11) begin
        n_checks++; if (wb_reg !== 5'd3 || wb_data !== 32'h64) begin n_fail++; $display("FAIL mul_wb got reg=%0d data=%h exp reg=3 data=00000064", wb_reg, wb_data); end
      end
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_exception(input logic div, input logic [31:0] code);
    logic e;
    next_edge();
    issue(1'b1, 5'd0, div ? 5'b00111 : 5'b00110, 5'd7);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) next_edge();
      md_rdy       = (c == 5);
      md_exception = (c == 3) || (c == 5);
      md_result    = 32'h0000_1234;
      if (c == 7) issue(1'b0, 5'd0, 5'd0, 5'd0);
      sample();
      e = (c <= 5);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL exc_stall div=%b c=%0d got=%b exp=%b", div, c, stall, e); end
      n_checks++; if (md_ctrl_div !== (div && c == 1) || md_ctrl_mult !== (!div && c == 1)) begin n_fail++; $display("FAIL exc_pulse div=%b c=%0d got mult=%b div=%b", div, c, md_ctrl_mult, md_ctrl_div); end
      e = (c == 6);
      n_checks++; if (wb_valid !== e) begin n_fail++; $display("FAIL exc_wbvalid div=%b c=%0d got=%b exp=%b", div, c, wb_valid, e); end
      if (c == 6) begin
        n_checks++; if (wb_reg !== 5'd30 || wb_data !== code) begin n_fail++; $display("FAIL exc_wb div=%b got reg=%0d data=%h exp reg=30 data=%h", div, wb_reg, wb_data, code); end
      end
    end
    md_rdy = 1'b0; md_exception = 1'b0;
  endtask

  task automatic test_rd_zero();
    logic e;
    next_edge();
    issue(1'b1, 5'd0, 5'b00110, 5'd0);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_edge();
      md_rdy    = (c == 3);
      md_result = 32'h0000_ABCD;
      if (c == 5) issue(1'b0, 5'd0, 5'd0, 5'd0);
      sample();
      e = (c <= 3);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL rd0_stall c=%0d got=%b exp=%b", c, stall, e); end
      e = (c >= 1 && c <= 4);
      n_checks++; if (busy !== e) begin n_fail++; $display("FAIL rd0_busy c=%0d got=%b exp=%b", c, busy, e); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_wbvalid c=%0d got=%b exp=0", c, wb_valid); end
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_stale_rdy();
    logic e;
    next_edge();
    issue(1'b1, 5'd0, 5'b00110, 5'd5);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_edge();
      md_rdy    = (c <= 1) || (c == 4);
      md_result = (c == 4) ? 32'h0000_0055 : 32'h0000_DEAD;
      if (c == 6) issue(1'b0, 5'd0, 5'd0, 5'd0);
      sample();
      e = (c <= 4);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL stale_stall c=%0d got=%b exp=%b", c, stall, e); end
      e = (c == 5);
      n_checks++; if (wb_valid !== e) begin n_fail++; $display("FAIL stale_wbvalid c=%0d got=%b exp=%b", c, wb_valid, e); end
      if (c == 5) begin
        n_checks++; if (wb_reg !== 5'd5 || wb_data !== 32'h55) begin n_fail++; $display("FAIL stale_wb got reg=%0d data=%h exp reg=5 data=00000055", wb_reg, wb_data); end
      end
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e;
    next_edge();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_edge();
      if (c <= 3) issue(1'b1, 5'd0, 5'b00110, 5'd1);
      else if (c <= 7) issue(1'b1, 5'd0, 5'b00110, 5'd2);
      else issue(1'b0, 5'd0, 5'd0, 5'd0);
      md_rdy    = (c == 2) || (c == 6);
      md_result = (c == 2) ? 32'h11 : ((c == 6) ? 32'h22 : 32'h0);
      sample();
      e = (c <= 2) || (c >= 4 && c <= 6);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall, e); end
      e = (c == 1) || (c == 5);
      n_checks++; if (md_ctrl_mult !== e) begin n_fail++; $display("FAIL b2b_pulse c=%0d got=%b exp=%b", c, md_ctrl_mult, e); end
      e = (c == 3) || (c == 7);
      n_checks++; if (wb_valid !== e) begin n_fail++; $display("FAIL b2b_wbvalid c=%0d got=%b exp=%b", c, wb_valid, e); end
      if (c == 3) begin
        n_checks++; if (wb_reg !== 5'd1 || wb_data !== 32'h11) begin n_fail++; $display("FAIL b2b_wb1 got reg=%0d data=%h exp reg=1 data=00000011", wb_reg, wb_data); end
      end
      if (c == 7) begin
        n_checks++; if (wb_reg !== 5'd2 || wb_data !== 32'h22) begin n_fail++; $display("FAIL b2b_wb2 got reg=%0d data=%h exp reg=2 data=00000022", wb_reg, wb_data); end
      end
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_non_multdiv();
    logic [4:0] opc [3];
    logic [4:0] alu [3];
    logic       vld [3];
    opc = '{5'd0, 5'd1, 5'd0};
    alu = '{5'b00101, 5'b00110, 5'b00110};
    vld = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      next_edge();
      issue(vld[i], opc[i], alu[i], 5'd9);
      md_rdy = 1'b1; md_result = 32'hCAFE_F00D;
      sample();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nonmd_stall v=%0d got=%b exp=0", i, stall); end
      next_edge();
      sample();
      n_checks++; if ({busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 4'b0000) begin n_fail++; $display("FAIL nonmd_ctl v=%0d got=%b exp=0000", i, {busy, md_ctrl_mult, md_ctrl_div, wb_valid}); end
      n_checks++; if (wb_reg !== 5'd2 || wb_data !== 32'h22) begin n_fail++; $display("FAIL nonmd_hold v=%0d got reg=%0d data=%h exp reg=2 data=00000022", i, wb_reg, wb_data); end
    end
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    md_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_edge();
    issue(1'b1, 5'd0, 5'b00110, 5'd4);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) next_edge();
      sample();
    end
    n_checks++; if (busy !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got busy=%b stall=%b exp 1/1", busy, stall); end
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    reset_n = 1'b0;
    #1;
    n_checks++; if ({busy, stall, wb_valid, md_ctrl_mult, md_ctrl_div} !== 5'b00000) begin n_fail++; $display("FAIL rstmid_ctl got=%b exp=00000", {busy, stall, wb_valid, md_ctrl_mult, md_ctrl_div}); end
    n_checks++; if (wb_reg !== 5'd0 || wb_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_wb got reg=%0d data=%h exp 0/0", wb_reg, wb_data); end
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_edge();
      md_rdy = 1'b1; md_result = 32'h99;
      sample();
      n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_post c=%0d got wb_valid=%b busy=%b exp 0/0", c, wb_valid, busy); end
    end
    md_rdy = 1'b0;
  endtask

`ifdef MULTDIV_TIMEOUT_EN
  task automatic test_timeout();
    logic e;
    next_edge();
    issue(1'b1, 5'd0, 5'b00110, 5'd9);
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) next_edge();
      if (c == 44) issue(1'b0, 5'd0, 5'd0, 5'd0);
      sample();
      e = (c <= 42);
      n_checks++; if (stall !== e) begin n_fail++; $display("FAIL tmo_stall c=%0d got=%b exp=%b", c, stall, e); end
      e = (c == 43);
      n_checks++; if (wb_valid !== e) begin n_fail++; $display("FAIL tmo_wbvalid c=%0d got=%b exp=%b", c, wb_valid, e); end
      if (c == 43) begin
        n_checks++; if (wb_reg !== 5'd30 || wb_data !== 32'd4) begin n_fail++; $display("FAIL tmo_wb got reg=%0d data=%h exp reg=30 data=00000004", wb_reg, wb_data); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_exception(1'b1, 32'd5);
    test_exception(1'b0, 32'd4);
    test_rd_zero();
    test_stale_rdy();
    test_back_to_back();
    test_non_multdiv();
    test_reset_mid();
`ifdef MULTDIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
